// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM: fetch / decode / exec / mem / writeback sequencing.
// Optional bounded memory wait (trap on timeout) enabled by MULTICYCLE_CTRL_MEM_TIMEOUT_EN.
module multicycle_ctrl #(
  parameter int unsigned OPW         = 4,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic [OPW-1:0] op_sel,
  output logic           mem_req,
  output logic           mem_we,
  output logic           addr_sel,
  output logic           ir_write,
  output logic           pc_write,
  output logic           pc_src,
  output logic           alu_src_imm,
  output logic           reg_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           retire,
  output logic           trap,
  output logic           halted
);

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_TRAP
  } state_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] opc_q, opc_d;

  function automatic logic is_rtype(input logic [OPW-1:0] op);
    return op == OPW'(0);
  endfunction

  function automatic logic is_aluimm(input logic [OPW-1:0] op);
    return (op >= OPW'(1)) && (op <= OPW'(9));
  endfunction

  function automatic logic is_lw(input logic [OPW-1:0] op);
    return op == OPW'(10);
  endfunction

  function automatic logic is_sw(input logic [OPW-1:0] op);
    return op == OPW'(11);
  endfunction

  function automatic logic is_beq(input logic [OPW-1:0] op);
    return op == OPW'(12);
  endfunction

  function automatic logic is_halt(input logic [OPW-1:0] op);
    return op == OPW'(15);
  endfunction

`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;

  // Count reaches MEM_TIMEOUT on this cycle's increment; a same-cycle ready wins.
  assign timeout = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
`else
  // MEM_TIMEOUT only matters in the timeout build; nothing is generated here.
  if (MEM_TIMEOUT == 0) begin : g_mem_timeout_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    alu_src_imm = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    retire      = 1'b0;
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
    // Cleared whenever not waiting, so every FETCH/MEM entry starts from zero.
    cnt_d       = '0;
    if ((state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif

    unique case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          opc_d    = opcode;
          state_d  = ST_DECODE;
        end
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
        else if (timeout) begin
          state_d = ST_TRAP;
        end
`endif
      end

      ST_DECODE: begin
        if (is_halt(opc_q)) begin
          state_d = ST_HALT;
        end else if (is_rtype(opc_q) || is_aluimm(opc_q) || is_lw(opc_q) ||
                     is_sw(opc_q) || is_beq(opc_q)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
        end
      end

      ST_EXEC: begin
        alu_src_imm = is_aluimm(opc_q) || is_lw(opc_q) || is_sw(opc_q);
        if (is_beq(opc_q)) begin
          pc_write = zero;
          pc_src   = zero;
          retire   = 1'b1;
          state_d  = ST_FETCH;
        end else if (is_lw(opc_q) || is_sw(opc_q)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        mem_req     = 1'b1;
        addr_sel    = 1'b1;
        mem_we      = is_sw(opc_q);
        alu_src_imm = 1'b1;
        if (mem_ready) begin
          if (is_sw(opc_q)) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
        else if (timeout) begin
          state_d = ST_TRAP;
        end
`endif
      end

      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lw(opc_q);
        reg_dst    = is_rtype(opc_q);
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_HALT: state_d = ST_HALT;
      ST_TRAP: state_d = ST_TRAP;

      default: state_d = ST_FETCH;
    endcase

    // Reset is synchronous, so the state may still be mid-instruction here.
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
    end
  end

  assign op_sel = opc_q;
  assign trap   = (state_q == ST_TRAP);
  assign halted = (state_q == ST_HALT);

endmodule
